// File: rtl/fpu_pkg.sv
// Shared FPU constants and types for the integer/float conversion unit.
package fpu_pkg;

    localparam logic OP_I2F = 1'b0;
    localparam logic OP_F2I = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0]  FP_BIAS      = 8'd127;
    localparam logic [7:0]  EXP_I2F_INIT = 8'd158;
    localparam logic [7:0]  EXP_MAX      = 8'd255;

    localparam logic [31:0] INT_MAX   = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] UINT_MAX  = 32'hFFFF_FFFF;
    // -2^31 as a float: the one e=158 value that still fits a signed int
    localparam logic [31:0] F_INT_MIN = 32'hCF00_0000;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/fp_int_converter.sv
// Iterative single-precision <-> 32-bit integer converter, truncating, one
// normalise/denormalise step per cycle over a shared shift register.
module fp_int_converter
    import fpu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op,
    input  logic        is_signed,
    input  logic [31:0] operand,
    output logic        done,
    output logic [31:0] result,
    output logic        invalid,
    output logic        inexact
);

    state_e      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    logic        sticky_q, sticky_d;
    logic [31:0] result_q, result_d;
    logic        invalid_q, invalid_d;
    logic        inexact_q, inexact_d;
    logic        done_q;
    logic        in_ready_q;

    logic [7:0]  e_s;
    logic        nan_s;
    logic [7:0]  sat_lim_s;

    assign e_s       = operand[30:23];
    assign nan_s     = (e_s == EXP_MAX) && (operand[22:0] != 23'd0);
    assign sat_lim_s = is_signed ? EXP_I2F_INIT : (EXP_I2F_INIT + 8'd1);

    // Next-state, datapath and result/flag loading
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        sticky_d  = sticky_q;
        result_d  = result_q;
        invalid_d = invalid_q;
        inexact_d = inexact_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sticky_d = 1'b0;
                    if (op == OP_I2F) begin
                        sign_d = is_signed & operand[31];
                        mag_d  = (is_signed & operand[31]) ? neg32(operand) : operand;
                        cnt_d  = EXP_I2F_INIT;
                        if (operand == 32'd0) begin
                            result_d  = 32'd0;
                            invalid_d = 1'b0;
                            inexact_d = 1'b0;
                            state_d   = ST_DONE;
                        end else begin
                            state_d = ST_NORM;
                        end
                    end else begin
                        sign_d = operand[31];
                        mag_d  = {1'b1, operand[22:0], 8'h00};
                        cnt_d  = EXP_I2F_INIT - e_s;
                        if (is_signed && (operand == F_INT_MIN)) begin
                            result_d  = INT_MIN;
                            invalid_d = 1'b0;
                            inexact_d = 1'b0;
                            state_d   = ST_DONE;
                        end else if ((e_s == EXP_MAX) || (e_s >= sat_lim_s)) begin
                            if (is_signed) begin
                                result_d = (nan_s || !operand[31]) ? INT_MAX : INT_MIN;
                            end else begin
                                result_d = (nan_s || !operand[31]) ? UINT_MAX : 32'd0;
                            end
                            invalid_d = 1'b1;
                            inexact_d = 1'b0;
                            state_d   = ST_DONE;
                        end else if (!is_signed && operand[31] && (e_s >= FP_BIAS)) begin
                            result_d  = 32'd0;
                            invalid_d = 1'b1;
                            inexact_d = 1'b0;
                            state_d   = ST_DONE;
                        end else if (e_s < FP_BIAS) begin
                            result_d  = 32'd0;
                            invalid_d = 1'b0;
                            inexact_d = |operand[30:0];
                            state_d   = ST_DONE;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_NORM: begin
                if (mag_q[31]) begin
                    result_d  = {sign_q, cnt_q, mag_q[30:8]};
                    invalid_d = 1'b0;
                    inexact_d = |mag_q[7:0];
                    state_d   = ST_DONE;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != 8'd0) begin
                    mag_d    = {1'b0, mag_q[31:1]};
                    sticky_d = sticky_q | mag_q[0];
                    cnt_d    = cnt_q - 8'd1;
                end else begin
                    result_d  = sign_q ? neg32(mag_q) : mag_q;
                    invalid_d = 1'b0;
                    inexact_d = sticky_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            mag_q      <= 32'd0;
            cnt_q      <= 8'd0;
            sign_q     <= 1'b0;
            sticky_q   <= 1'b0;
            result_q   <= 32'd0;
            invalid_q  <= 1'b0;
            inexact_q  <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            sticky_q   <= sticky_d;
            result_q   <= result_d;
            invalid_q  <= invalid_d;
            inexact_q  <= inexact_d;
            done_q     <= (state_d == ST_DONE);
            in_ready_q <= (state_d == ST_IDLE);
        end
    end

    assign in_ready = in_ready_q;
    assign done     = done_q;
    assign result   = result_q;
    assign invalid  = invalid_q;
    assign inexact  = inexact_q;

endmodule

// File: tb/tb_fp_int_converter.sv
// Directed-vector bench for fp_int_converter: results, flags, latency and reset.
module tb_fp_int_converter;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] operand = 32'd0;
    logic        done;
    logic [31:0] result;
    logic        invalid;
    logic        inexact;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    fp_int_converter dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .is_signed(is_signed),
        .operand  (operand),
        .done     (done),
        .result   (result),
        .invalid  (invalid),
        .inexact  (inexact)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One request; latency counts the accept edge as 1
    task automatic run(input string tag, input logic o, input logic s, input logic [31:0] val,
                       input logic [31:0] e_res, input logic e_inv, input logic e_inx,
                       input int e_lat);
        int n;
        @(negedge CLK);
        chk({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
        op = o; is_signed = s; operand = val; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0; operand = 32'hDEAD_BEEF; op = ~o; is_signed = ~s;
        n = 1;
        while (!done && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, ".lat"}, n, e_lat);
        chk({tag, ".res"}, result, e_res);
        chk({tag, ".flags"}, {30'd0, invalid, inexact}, {30'd0, e_inv, e_inx});
        @(posedge CLK); #1;
        chk({tag, ".pulse"}, {31'd0, done}, 32'd0);
        chk({tag, ".hold"}, result, e_res);
    endtask

    initial begin
        int dc0;
        #12;
        chk("rst.ready", {31'd0, in_ready}, 32'd1);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.res", result, 32'd0);
        chk("rst.flags", {30'd0, invalid, inexact}, 32'd0);
        @(negedge CLK); RESETn = 1'b1;

        run("i2f_s1",     1'b0, 1'b1, 32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0, 33);
        run("i2f_sm1",    1'b0, 1'b1, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 1'b0, 33);
        run("i2f_smin",   1'b0, 1'b1, 32'h8000_0000, 32'hCF00_0000, 1'b0, 1'b0, 2);
        run("i2f_u2p31",  1'b0, 1'b0, 32'h8000_0000, 32'h4F00_0000, 1'b0, 1'b0, 2);
        run("i2f_uinx",   1'b0, 1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b0, 1'b1, 9);
        run("i2f_zero",   1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
        run("f2i_pi",     1'b1, 1'b1, 32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b1, 32);
        run("f2i_one",    1'b1, 1'b1, 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 33);
        run("f2i_nan",    1'b1, 1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        run("f2i_uneg",   1'b1, 1'b0, 32'hBF80_0000, 32'h0000_0000, 1'b1, 1'b0, 1);
        run("f2i_smin",   1'b1, 1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
        run("f2i_s2p31",  1'b1, 1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        run("f2i_u2p31",  1'b1, 1'b0, 32'h4F00_0000, 32'h8000_0000, 1'b0, 1'b0, 2);
        run("f2i_u2p32",  1'b1, 1'b0, 32'h4F80_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
        run("f2i_half",   1'b1, 1'b1, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 1);

        // Mid-operation reset with an ignored second request
        @(negedge CLK);
        op = 1'b0; is_signed = 1'b1; operand = 32'h0000_0001; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0; operand = 32'hDEAD_BEEF;
        dc0 = done_cnt;
        repeat (4) @(posedge CLK);
        #1;
        op = 1'b1; operand = 32'h3F80_0000; in_valid = 1'b1;
        chk("mid.busy", {31'd0, in_ready}, 32'd0);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RESETn = 1'b0;
        #1;
        chk("mid.ready", {31'd0, in_ready}, 32'd1);
        chk("mid.done", {31'd0, done}, 32'd0);
        chk("mid.res", result, 32'd0);
        chk("mid.flags", {30'd0, invalid, inexact}, 32'd0);
        @(negedge CLK); RESETn = 1'b1;
        @(posedge CLK); #1;
        chk("mid.ready2", {31'd0, in_ready}, 32'd1);
        chk("mid.nopulse", done_cnt, dc0);
        run("post_rst",   1'b0, 1'b0, 32'h8000_0000, 32'h4F00_0000, 1'b0, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_int_converter.md
# fp_int_converter

Multi-cycle IEEE-754 single-precision ↔ 32-bit integer converter for the CPU's FPU. It provides the conversions the combinational add/sub path lacks:
- integer → float (packing a magnitude into sign/exponent/fraction)
- float → integer (unpacking and denormalising)

Normalisation and denormalisation are iterative (one bit per cycle) to keep area small. A valid/ready handshake accepts requests, and completion is a one-cycle done pulse.

## Interface
- No parameters; all constants come from the shared package.
- CLK  in  1  system clock, all state on rising edge
- RESETn  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  high only in IDLE; request accepted on edge with in_valid & in_ready
- op  in  1  0 = int→float, 1 = float→int
- is_signed  in  1  1 = operand/result integer is two's complement, 0 = unsigned
- operand  in  32  integer or IEEE-754 word
- done  out  1  one-cycle pulse, result/flags valid
- result  out  32  converted value, held until next accept
- invalid  out  1  NaN/Inf/out-of-range on float→int, held with result
- inexact  out  1  nonzero bits discarded, held with result

## Operation
- Rounding is round-toward-zero (truncate) in both directions, matching the add/sub datapath.
- States: IDLE, NORM, SHIFT, DONE.
- IDLE → (accept, op=0, magnitude≠0) NORM; (op=0, magnitude=0) DONE; (op=1, special case) DONE; (op=1, normal) SHIFT.
- Int→float, accept:
  - sign = is_signed & operand[31]; mag = sign ? −operand : operand (0x80000000 gives magnitude 2^31); exp = 158.
  - NORM, mag[31]=0: mag <<= 1, exp −= 1.
  - NORM, mag[31]=1: result = {sign, exp, mag[30:8]}, inexact = |mag[7:0], → DONE.
  - Zero input: result 0x00000000, flags 0.
- Float→int, accept, with e = operand[30:23]:
  - e=255, or e≥158 (signed) / e≥159 (unsigned): invalid = 1; result saturates.
    - signed: NaN or +: 0x7FFFFFFF; −: 0x80000000.
    - unsigned: NaN or +: 0xFFFFFFFF; −: 0.
  - Exception to the above: signed, operand = 0xCF000000 (−2^31) → 0x80000000, no flags.
  - Unsigned, sign=1, value ≤ −1.0 → invalid, result 0.
  - e<127 (any sign, includes zero/denormals) → result 0, inexact = |operand[30:0].
  - Otherwise: mag = {1, operand[22:0], 8'b0}; cnt = 158−e → SHIFT.
  - SHIFT, cnt≠0: mag >>= 1, sticky |= shifted-out bit, cnt −= 1.
  - SHIFT, cnt=0: result = sign ? −mag : mag; inexact = sticky; → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- Flags and result are loaded only on the transition into DONE.

## Timing
- Reset values: state IDLE, in_ready 1, done 0, result 0x00000000, invalid 0, inexact 0.
- Latency, counted in edges after the accept edge: done is high in the cycle that follows.
  - Int→float: lzc(mag)+2; zero input: 1.
  - Float→int: (158−e)+2; special cases: 1.
  - Worst case: 33.
- in_valid while busy (state≠IDLE) is ignored; no queuing, no back-to-back accept in the DONE cycle.
- operand/op/is_signed are sampled only at accept; later changes have no effect.
- RESETn asserted mid-operation: immediate return to IDLE, outputs to reset values, no done pulse.

## Structure
- Shared package fpu_pkg:
  - op encodings (OP_I2F, OP_F2I)
  - state enum
  - FP_BIAS=127, EXP_I2F_INIT=158, EXP_MAX=255
  - saturation constants (INT_MAX, INT_MIN, UINT_MAX)
- Single module, no sub-module: the datapath is one 32-bit shift register, an 8-bit exponent/count register, a negator and a sticky bit.

## Test plan
- I2F signed 0x00000001 → result 0x3F800000, flags 0, done 33 cycles after accept.
- I2F signed 0x80000000 → 0xCF000000, done at cycle 2; unsigned 0x80000000 → 0x4F000000.
- I2F unsigned 0x01000001 → 0x4B800000, inexact=1; I2F 0 → 0x00000000, done at cycle 1.
- F2I signed 0xC0490FDB (−3.14159) → 0xFFFFFFFD, inexact=1, done at cycle 32.
- F2I specials:
  - signed 0x7FC00000 → 0x7FFFFFFF, invalid=1
  - unsigned 0xBF800000 → 0x00000000, invalid=1
  - signed 0xCF000000 → 0x80000000, no flags
  - 0x3F000000 (0.5) → 0, inexact=1
- Accept I2F 0x00000001, pulse in_valid again at cycle 5 (ignored), assert RESETn low at cycle 10:
  - no done pulse; outputs at reset values; in_ready=1 after release.
  - next request completes normally.
